// File: rtl/sram_arbiter.sv
// Two-port arbiter and read sequencer sharing one sram read port between
// instruction fetch (port 0) and data load (port 1); one read accepted per cycle.
module sram_arbiter #(
    parameter int addr        = 4,
    parameter int width       = 8,
    parameter int rd_lat      = 1,
    parameter bit round_robin = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [addr-1:0]  addr0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [width-1:0] rdata0,
    input  logic             req1,
    input  logic [addr-1:0]  addr1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [width-1:0] rdata1,
    output logic             cs,
    output logic [addr-1:0]  address,
    input  logic [width-1:0] data_out,
    output logic             busy
);

    // One owner/valid slot per cycle from the cs cycle up to the data cycle.
    localparam int DEPTH = rd_lat + 1;

    logic [1:0]       gnt;
    logic             last_gnt;
    logic [DEPTH-1:0] vld_p1;
    logic [DEPTH-1:0] own_p1;
    logic [width-1:0] rdata0_q;
    logic [width-1:0] rdata1_q;

    // bit0 = port 0, bit1 = port 1; last = port granted most recently.
    function automatic logic [1:0] arbitrate(input logic r0, input logic r1, input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (r0 && r1) begin
            if (round_robin && !last)
                g = 2'b10;
            else
                g = 2'b01;
        end else if (r0) begin
            g = 2'b01;
        end else if (r1) begin
            g = 2'b10;
        end
        return g;
    endfunction

    always_comb begin
        gnt = 2'b00;
        if (!rst)
            gnt = arbitrate(req0, req1, last_gnt);
    end

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Stage p0: drive the sram with the granted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs       <= 1'b0;
            address  <= '0;
            last_gnt <= 1'b1;
        end else begin
            cs <= |gnt;
            if (|gnt) begin
                address  <= gnt[1] ? addr1 : addr0;
                last_gnt <= gnt[1];
            end
        end
    end

    // Stage p1..p(rd_lat+1): track owner of each in-flight read until its data returns.
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= '0;
        else
            vld_p1 <= {vld_p1[DEPTH-2:0], |gnt};
    end

    always_ff @(posedge clk) begin
        own_p1 <= {own_p1[DEPTH-2:0], gnt[1]};
    end

    assign rvalid0 = vld_p1[rd_lat] & ~own_p1[rd_lat];
    assign rvalid1 = vld_p1[rd_lat] &  own_p1[rd_lat];
    assign busy    = |vld_p1;

    // Return stage: data passes straight through; the idle port keeps its last value.
    always_ff @(posedge clk) begin
        if (rvalid0)
            rdata0_q <= data_out;
        if (rvalid1)
            rdata1_q <= data_out;
    end

    assign rdata0 = rvalid0 ? data_out : rdata0_q;
    assign rdata1 = rvalid1 ? data_out : rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: four instances (lat1/rr, lat1/fixed, lat2/rr, lat4/rr)
// share stimulus, each backed by a small sram model with mem[a] = 8'hA0 + a.
module tb_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] addr0, addr1;

    logic [3:0] gnt0_v, gnt1_v, rvalid0_v, rvalid1_v, cs_v, busy_v;
    logic [7:0] rdata0_v [4];
    logic [7:0] rdata1_v [4];
    logic [3:0] address_v [4];
    logic [7:0] data_out_v [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : inst
        localparam int LAT = (g == 3) ? 4 : (g == 2) ? 2 : 1;
        localparam bit RR  = (g == 1) ? 1'b0 : 1'b1;
        logic [7:0] sh [4];

        always @(posedge clk) begin
            sh[0] <= cs_v[g] ? (8'hA0 + {4'h0, address_v[g]}) : 8'h00;
            for (int i = 1; i < 4; i++)
                sh[i] <= sh[i-1];
        end
        assign data_out_v[g] = sh[LAT-1];

        sram_arbiter #(.addr(4), .width(8), .rd_lat(LAT), .round_robin(RR)) dut (
            .clk(clk), .rst(rst),
            .req0(req0), .addr0(addr0), .gnt0(gnt0_v[g]), .rvalid0(rvalid0_v[g]), .rdata0(rdata0_v[g]),
            .req1(req1), .addr1(addr1), .gnt1(gnt1_v[g]), .rvalid1(rvalid1_v[g]), .rdata1(rdata1_v[g]),
            .cs(cs_v[g]), .address(address_v[g]), .data_out(data_out_v[g]), .busy(busy_v[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 4'h0; addr1 = 4'h0;
        next_cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 4'h0; addr1 = 4'h0;
        #1;
        next_cyc();
        // Reset state, and grants suppressed while rst is high.
        req0 = 1'b1; req1 = 1'b1;
        mid();
        chk("rst_cs", cs_v[0], 1'b0);
        chk("rst_addr", address_v[0], 4'h0);
        chk("rst_busy", busy_v[0], 1'b0);
        chk("rst_rv", {rvalid0_v[0], rvalid1_v[0]}, 2'b00);
        chk("rst_gnt", {gnt0_v[0], gnt1_v[0]}, 2'b00);
        next_cyc();
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;

        // Single read on port 0, rd_lat=1.
        req0 = 1'b1; addr0 = 4'h3;
        mid();
        chk("single_gnt", {gnt1_v[0], gnt0_v[0]}, 2'b01);
        chk("single_busy_t", busy_v[0], 1'b0);
        next_cyc();
        req0 = 1'b0;
        mid();
        chk("single_cs", cs_v[0], 1'b1);
        chk("single_address", address_v[0], 4'h3);
        chk("single_busy_t1", busy_v[0], 1'b1);
        chk("single_rv_t1", rvalid0_v[0], 1'b0);
        next_cyc();
        mid();
        chk("single_rv", {rvalid1_v[0], rvalid0_v[0]}, 2'b01);
        chk("single_rdata", rdata0_v[0], 8'hA3);
        chk("single_busy_t2", busy_v[0], 1'b1);
        chk("single_cs_off", cs_v[0], 1'b0);
        chk("single_addr_hold", address_v[0], 4'h3);
        next_cyc();
        mid();
        chk("single_rv_end", rvalid0_v[0], 1'b0);
        chk("single_busy_end", busy_v[0], 1'b0);
        chk("single_rdata_hold", rdata0_v[0], 8'hA3);
        next_cyc();

        // Round-robin conflict: grants 0,1,0,1, returns alternate with no bubbles.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req0 = (c < 4); req1 = (c < 4); addr0 = 4'h1; addr1 = 4'h2;
            mid();
            if (c < 4) begin
                chk($sformatf("rr_gnt0_c%0d", c), gnt0_v[0], (c % 2 == 0));
                chk($sformatf("rr_gnt1_c%0d", c), gnt1_v[0], (c % 2 == 1));
            end
            chk($sformatf("rr_rv0_c%0d", c), rvalid0_v[0], (c >= 2 && c <= 5 && c % 2 == 0));
            chk($sformatf("rr_rv1_c%0d", c), rvalid1_v[0], (c >= 2 && c <= 5 && c % 2 == 1));
            if (c >= 2 && c <= 5 && c % 2 == 0) chk($sformatf("rr_rd0_c%0d", c), rdata0_v[0], 8'hA1);
            if (c >= 2 && c <= 5 && c % 2 == 1) chk($sformatf("rr_rd1_c%0d", c), rdata1_v[0], 8'hA2);
            next_cyc();
        end

        // Fixed priority: port 0 wins every conflict; port 1 served once port 0 drops.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req0 = (c < 3); req1 = (c < 4); addr0 = 4'h1; addr1 = 4'h2;
            mid();
            if (c < 4) begin
                chk($sformatf("fp_gnt0_c%0d", c), gnt0_v[1], (c < 3));
                chk($sformatf("fp_gnt1_c%0d", c), gnt1_v[1], (c == 3));
            end
            chk($sformatf("fp_rv0_c%0d", c), rvalid0_v[1], (c >= 2 && c <= 4));
            chk($sformatf("fp_rv1_c%0d", c), rvalid1_v[1], (c == 5));
            if (c >= 2 && c <= 4) chk($sformatf("fp_rd0_c%0d", c), rdata0_v[1], 8'hA1);
            if (c == 5) chk("fp_rd1", rdata1_v[1], 8'hA2);
            next_cyc();
        end

        // Streaming port 1 across the full address range including wrap at 15.
        do_reset();
        for (int c = 0; c < 19; c++) begin
            req1 = (c < 16); addr1 = 4'(c);
            mid();
            if (c < 16) chk($sformatf("st_gnt1_c%0d", c), gnt1_v[0], 1'b1);
            chk($sformatf("st_rv1_c%0d", c), rvalid1_v[0], (c >= 2 && c <= 17));
            chk($sformatf("st_rv0_c%0d", c), rvalid0_v[0], 1'b0);
            if (c >= 2 && c <= 17) chk($sformatf("st_rd1_c%0d", c), rdata1_v[0], 8'hA0 + 8'(c - 2));
            next_cyc();
        end
        req1 = 1'b0;

        // Reset mid-flight with rd_lat=2: the in-flight read is dropped.
        do_reset();
        req0 = 1'b1; addr0 = 4'h5;
        mid();
        chk("mf_gnt0", gnt0_v[2], 1'b1);
        next_cyc();
        req0 = 1'b0; rst = 1'b1;
        mid();
        chk("mf_cs_t1", cs_v[2], 1'b1);
        chk("mf_busy_t1", busy_v[2], 1'b1);
        next_cyc();
        rst = 1'b0;
        mid();
        chk("mf_cs_t2", cs_v[2], 1'b0);
        chk("mf_busy_t2", busy_v[2], 1'b0);
        chk("mf_rv_t2", {rvalid0_v[2], rvalid1_v[2]}, 2'b00);
        next_cyc();
        req0 = 1'b1; req1 = 1'b1; addr1 = 4'h6;
        mid();
        chk("mf_rv_t3", {rvalid0_v[2], rvalid1_v[2]}, 2'b00);
        chk("mf_conflict", {gnt1_v[2], gnt0_v[2]}, 2'b01);
        next_cyc();
        req0 = 1'b0; req1 = 1'b0;

        // Latency sweep rd_lat=4: single read returns exactly 5 cycles after grant.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req0 = (c == 0); addr0 = 4'h7;
            mid();
            if (c == 0) chk("lat_gnt0", gnt0_v[3], 1'b1);
            chk($sformatf("lat_rv0_c%0d", c), rvalid0_v[3], (c == 5));
            chk($sformatf("lat_rv1_c%0d", c), rvalid1_v[3], 1'b0);
            if (c == 5) chk("lat_rd0", rdata0_v[3], 8'hA7);
            next_cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
